// File: rtl/switch_pkg.sv
// switch_pkg: shared definitions for the switch_bank debouncer.
//   - default parameter values for the bank
//   - chan_evt_t: per-channel output bundle (level plus event pulses)
//   - clog2: width helper used for counter sizing
package switch_pkg;

  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_DIV_WIDTH    = 8;
  localparam int DEF_STABLE_TICKS = 8;
  localparam int DEF_HOLD_TICKS   = 64;
  localparam int DEF_ACTIVE_LOW   = 1;

  // One channel's outputs. 'release' is a language keyword, hence release_p.
  typedef struct packed {
    logic level;
    logic press;
    logic release_p;
    logic hold;
  } chan_evt_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/switch_channel.sv
// switch_channel: one debounced switch.
//   sys_clock  : clock
//   reset      : synchronous, active-high
//   tick       : shared sample strobe from the bank divider
//   switch_in  : raw asynchronous pin
//   evt        : registered level and one-cycle press/release/hold pulses
// The pin is synchronised, normalised to 1 = pressed, and only accepted as a
// new level after STABLE_TICKS consecutive disagreeing samples.
module switch_channel
  import switch_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
  input  logic      sys_clock,
  input  logic      reset,
  input  logic      tick,
  input  logic      switch_in,
  output chan_evt_t evt
);

  localparam int SW = clog2(STABLE_TICKS);
  localparam int HW = clog2(HOLD_TICKS + 1);
  // Pin value when the switch is not pressed.
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  logic [1:0]    sync_pipe;
  logic          pressed_raw;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic          level, level_q;
  logic          press, rel, hold;

  assign pressed_raw = sync_pipe[1] ^ IDLE_PIN;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      // Synchroniser loads the released pin value so reset never looks like a press.
      sync_pipe <= {2{IDLE_PIN}};
      stab_cnt  <= '0;
      hold_cnt  <= '0;
      level     <= 1'b0;
      level_q   <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      hold      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], switch_in};
      level_q   <= level;
      press     <= level & ~level_q;
      rel       <= ~level & level_q;
      // Fires on the tick that takes hold_cnt to HOLD_TICKS; saturation makes it one-shot.
      hold      <= tick & level & (hold_cnt == HOLD_LAST);

      if (tick) begin
        if (pressed_raw == level) begin
          stab_cnt <= '0;
        end else if (stab_cnt == STAB_LAST) begin
          level    <= ~level;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end

      if (!level)
        hold_cnt <= '0;
      else if (tick && hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign evt.level     = level;
  assign evt.press     = press;
  assign evt.release_p = rel;
  assign evt.hold      = hold;

endmodule

// File: rtl/switch_bank.sv
// switch_bank: CHANNELS independent switch debouncers sharing one sample divider.
//   sys_clock     : clock
//   reset         : synchronous, active-high
//   switch_in     : raw asynchronous pins
//   level         : debounced pressed state (1 = pressed)
//   press         : one-cycle pulse when level rises
//   release_pulse : one-cycle pulse when level falls ('release' is a keyword)
//   hold          : one-cycle pulse after HOLD_TICKS ticks of continuous press
//   tick          : shared sample strobe, one cycle every 2^DIV_WIDTH cycles
module switch_bank
  import switch_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int DIV_WIDTH    = DEF_DIV_WIDTH,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
  input  logic                sys_clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] switch_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] hold,
  output logic                tick
);

  logic [DIV_WIDTH-1:0] div_cnt;
  chan_evt_t            evt [CHANNELS];

  always_ff @(posedge sys_clock) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= div_cnt + 1'b1;
  end

  // All-ones for one cycle, then the counter wraps to zero.
  assign tick = &div_cnt;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    switch_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .sys_clock(sys_clock),
      .reset    (reset),
      .tick     (tick),
      .switch_in(switch_in[g]),
      .evt      (evt[g])
    );
    assign level[g]         = evt[g].level;
    assign press[g]         = evt[g].press;
    assign release_pulse[g] = evt[g].release_p;
    assign hold[g]          = evt[g].hold;
  end

endmodule

// File: tb/tb_switch_bank.sv
// Bench for switch_bank: CHANNELS=2, DIV_WIDTH=2, STABLE_TICKS=4, HOLD_TICKS=8,
// ACTIVE_LOW=1. Sample index k counts negedges since the last reset release;
// tick cycles are k%4==3, pressed_raw follows a pin driven at sample k from
// sample k+2, and level moves one sample after the 4th disagreeing tick.
module tb_switch_bank;

  localparam int CH = 2;

  logic          sys_clock = 1'b0;
  logic          reset     = 1'b1;
  logic [CH-1:0] switch_in = 2'b11;
  logic [CH-1:0] level, press, release_pulse, hold;
  logic          tick;

  switch_bank #(
    .CHANNELS(CH), .DIV_WIDTH(2), .STABLE_TICKS(4), .HOLD_TICKS(8), .ACTIVE_LOW(1)
  ) dut (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .switch_in    (switch_in),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .hold         (hold),
    .tick         (tick)
  );

  always #5 sys_clock = ~sys_clock;

  int total = 0, bad = 0, k = 0, ovl = 0;
  int pc[CH], rc[CH], hc[CH], tp[CH], tr[CH], th[CH], trise[CH];
  logic [CH-1:0] lvl_prev, lvl_seen;

  typedef struct {
    logic [1:0] sw;
    int         ncyc;
    logic [1:0] lvl;
    int p0, p1, r0, r1, h0, h1;
    int tp0, tp1, tr0, tr1, th0;   // first pulse sample index, -1 = none
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < CH; c++) begin
      pc[c] = 0; rc[c] = 0; hc[c] = 0;
      tp[c] = -1; tr[c] = -1; th[c] = -1; trise[c] = -1;
    end
    lvl_prev = level;
    lvl_seen = '0;
  endtask

  task automatic step();
    @(negedge sys_clock);
    k++;
    for (int c = 0; c < CH; c++) begin
      if (press[c])         begin pc[c]++; if (tp[c] < 0) tp[c] = k; end
      if (release_pulse[c]) begin rc[c]++; if (tr[c] < 0) tr[c] = k; end
      if (hold[c])          begin hc[c]++; if (th[c] < 0) th[c] = k; end
      if (int'(press[c]) + int'(release_pulse[c]) + int'(hold[c]) > 1) ovl++;
      if (level[c] && !lvl_prev[c] && trise[c] < 0) trise[c] = k;
      if (level[c]) lvl_seen[c] = 1'b1;
    end
    lvl_prev = level;
  endtask

  initial begin
    // ch0 press at k=12: ticks 15,19,23,27 -> level 28, press 29, hold 28+32=60
    vecs[0] = '{2'b10, 100, 2'b01, 1, 0, 0, 0, 1, 0, 29, -1, -1, -1, 60};
    // release at k=112: ticks 115..127 -> level falls 128, release 129, no 2nd hold
    vecs[1] = '{2'b11, 30, 2'b00, 0, 0, 1, 0, 0, 0, -1, -1, 129, -1, -1};
    // both low at k=142: ticks 147..159 -> level 160, both press at 161
    vecs[2] = '{2'b00, 30, 2'b11, 1, 1, 0, 0, 0, 0, 161, 161, -1, -1, -1};
    // both high at k=172: level falls 188 (one tick short of hold), release 189
    vecs[3] = '{2'b11, 30, 2'b00, 0, 0, 1, 1, 0, 0, -1, -1, 189, 189, -1};

    // Reset with pins idle.
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    chk("reset level",   int'(level), 0);
    chk("reset press",   int'(press), 0);
    chk("reset release", int'(release_pulse), 0);
    chk("reset hold",    int'(hold), 0);
    chk("reset tick",    int'(tick), 0);
    reset = 1'b0;
    k = 0;
    clr();

    // Divider phase: first tick at k=3, then every 4 cycles.
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("tick k=%0d", k), int'(tick), (k % 4 == 3) ? 1 : 0);
    end

    for (int i = 0; i < 4; i++) begin
      switch_in = vecs[i].sw;
      clr();
      repeat (vecs[i].ncyc) step();
      chk($sformatf("row%0d level", i),    int'(level), int'(vecs[i].lvl));
      chk($sformatf("row%0d press0", i),   pc[0], vecs[i].p0);
      chk($sformatf("row%0d press1", i),   pc[1], vecs[i].p1);
      chk($sformatf("row%0d release0", i), rc[0], vecs[i].r0);
      chk($sformatf("row%0d release1", i), rc[1], vecs[i].r1);
      chk($sformatf("row%0d hold0", i),    hc[0], vecs[i].h0);
      chk($sformatf("row%0d hold1", i),    hc[1], vecs[i].h1);
      chk($sformatf("row%0d t_press0", i), tp[0], vecs[i].tp0);
      chk($sformatf("row%0d t_press1", i), tp[1], vecs[i].tp1);
      chk($sformatf("row%0d t_rel0", i),   tr[0], vecs[i].tr0);
      chk($sformatf("row%0d t_rel1", i),   tr[1], vecs[i].tr1);
      chk($sformatf("row%0d t_hold0", i),  th[0], vecs[i].th0);
    end

    // Bounce: 3 low / 3 high for 42 cycles, then settle high. No low window
    // spans two ticks, so at most two consecutive disagreeing samples occur.
    clr();
    for (int p = 0; p < 7; p++) begin
      switch_in = 2'b10; repeat (3) step();
      switch_in = 2'b11; repeat (3) step();
    end
    repeat (24) step();
    chk("bounce level seen", int'(lvl_seen[0]), 0);
    chk("bounce press",      pc[0], 0);
    chk("bounce release",    rc[0], 0);
    chk("bounce hold",       hc[0], 0);

    // Reset mid-qualification: drive at k=268, ticks 271 and 275 counted.
    switch_in = 2'b10;
    clr();
    repeat (8) step();
    chk("pre-reset level", int'(level), 0);
    reset = 1'b1;
    repeat (3) step();
    chk("mid reset level", int'(level), 0);
    chk("mid reset tick",  int'(tick), 0);
    chk("mid reset press", int'(press), 0);
    reset = 1'b0;
    k = 0;
    clr();
    // Fresh qualification: ticks 3,7,11,15 -> level 16, press 17.
    repeat (24) step();
    chk("post-reset rise0",  trise[0], 16);
    chk("post-reset t_press0", tp[0], 17);
    chk("post-reset press0", pc[0], 1);
    chk("post-reset press1", pc[1], 0);
    chk("post-reset level",  int'(level), 1);

    chk("pulses exclusive", ovl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
